// File: rtl/cpu_program_loader.sv
// cpu_program_loader: parses HEADER/LEN/payload byte frames into CPU load strobes
// and holds the CPU in reset until a RUN header arrives.
module cpu_program_loader #(
    parameter int IADDR_W = 5,
    parameter int DADDR_W = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [7:0]         cpu_input,
    output logic [IADDR_W-1:0] load_address,
    output logic               load,
    output logic               is_instruction,
    output logic               cpu_reset,
    output logic               frame_done,
    output logic               timeout_err,
    output logic               busy
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [IADDR_W-1:0] DMASK = IADDR_W'((1 << DADDR_W) - 1);

    typedef enum logic [1:0] {IDLE, LEN, DATA} state_t;

    state_t             state, state_n;
    logic               inst_q, inst_n;
    logic [IADDR_W-1:0] addr_q, addr_n, addr_inc, hdr_addr;
    logic [7:0]         cnt_q, cnt_n;
    logic [TW-1:0]      idle_q, idle_n;
    logic [7:0]         cpu_input_n;
    logic [IADDR_W-1:0] load_address_n;
    logic               load_n, is_instruction_n, cpu_reset_n, frame_done_n, timeout_err_n;
    logic               acc, expire;

    assign in_ready = ~reset;
    assign busy     = state != IDLE;
    assign acc      = in_valid && in_ready;
    assign addr_inc = addr_q + 1'b1;
    assign hdr_addr = in_data[7] ? IADDR_W'(in_data[4:0]) : IADDR_W'(in_data[4:0]) & DMASK;
    // Expire on the edge that would complete TIMEOUT idle cycles, so the pulse cycle is already IDLE.
    assign expire   = TIMEOUT != 0 && busy && !acc && idle_q == TW'(TIMEOUT - 1);

    always_comb begin
        state_n          = state;
        inst_n           = inst_q;
        addr_n           = addr_q;
        cnt_n            = cnt_q;
        idle_n           = (busy && !acc) ? idle_q + 1'b1 : '0;
        cpu_input_n      = cpu_input;
        load_address_n   = load_address;
        is_instruction_n = is_instruction;
        cpu_reset_n      = cpu_reset;
        load_n           = 1'b0;
        frame_done_n     = 1'b0;
        timeout_err_n    = 1'b0;
        if (state == IDLE && acc) begin
            if (in_data[6]) begin
                cpu_reset_n  = 1'b0;
                frame_done_n = 1'b1;
            end else begin
                inst_n      = in_data[7];
                addr_n      = hdr_addr;
                cpu_reset_n = 1'b1;
                state_n     = LEN;
            end
        end else if (state == LEN && acc) begin
            cnt_n        = in_data;
            frame_done_n = in_data == 8'd0;
            state_n      = (in_data == 8'd0) ? IDLE : DATA;
        end else if (state == DATA && acc) begin
            load_n           = 1'b1;
            cpu_input_n      = in_data;
            load_address_n   = addr_q;
            is_instruction_n = inst_q;
            addr_n           = inst_q ? addr_inc : addr_inc & DMASK;
            cnt_n            = cnt_q - 8'd1;
            frame_done_n     = cnt_q == 8'd1;
            state_n          = (cnt_q == 8'd1) ? IDLE : DATA;
        end else if (expire) begin
            timeout_err_n = 1'b1;
            state_n       = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            inst_q         <= 1'b0;
            addr_q         <= '0;
            cnt_q          <= '0;
            idle_q         <= '0;
            cpu_input      <= '0;
            load_address   <= '0;
            is_instruction <= 1'b0;
            cpu_reset      <= 1'b1;
            load           <= 1'b0;
            frame_done     <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            state          <= state_n;
            inst_q         <= inst_n;
            addr_q         <= addr_n;
            cnt_q          <= cnt_n;
            idle_q         <= idle_n;
            cpu_input      <= cpu_input_n;
            load_address   <= load_address_n;
            is_instruction <= is_instruction_n;
            cpu_reset      <= cpu_reset_n;
            load           <= load_n;
            frame_done     <= frame_done_n;
            timeout_err    <= timeout_err_n;
        end
    end
endmodule

// File: tb/tb_cpu_program_loader.sv
// tb_cpu_program_loader: directed frames with a scoreboard of expected load/done/timeout events.
module tb_cpu_program_loader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, load, is_instruction, cpu_reset, frame_done, timeout_err, busy;
    logic [7:0] cpu_input;
    logic [4:0] load_address;

    typedef struct {
        logic       ld;
        logic [7:0] d;
        logic [4:0] a;
        logic       i;
        logic       dn;
        logic       to;
    } ev_t;

    ev_t q[$];
    ev_t e;
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    cpu_program_loader #(.IADDR_W(5), .DADDR_W(4), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .cpu_input(cpu_input), .load_address(load_address), .load(load),
        .is_instruction(is_instruction), .cpu_reset(cpu_reset), .frame_done(frame_done),
        .timeout_err(timeout_err), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_load(input logic [4:0] a, input logic [7:0] d, input logic i, input logic dn);
        q.push_back('{ld: 1'b1, d: d, a: a, i: i, dn: dn, to: 1'b0});
    endtask

    task automatic exp_flag(input logic dn, input logic to);
        q.push_back('{ld: 1'b0, d: 8'h00, a: 5'd0, i: 1'b0, dn: dn, to: to});
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && (load || frame_done || timeout_err)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event load=%0b done=%0b tmo=%0b addr=%0d data=%0h", load, frame_done, timeout_err, load_address, cpu_input);
            end else begin
                e = q.pop_front();
                chk("ev_load", load, e.ld);
                chk("ev_done", frame_done, e.dn);
                chk("ev_tmo", timeout_err, e.to);
                if (e.ld) begin
                    chk("ev_addr", load_address, e.a);
                    chk("ev_data", cpu_input, e.d);
                    chk("ev_inst", is_instruction, e.i);
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_load", load, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", load_address, 0);
        chk("rst_data", cpu_input, 0);
        reset = 1'b0;
        #1;
        chk("in_ready", in_ready, 1);

        exp_load(5'd3, 8'hA1, 1, 0);
        exp_load(5'd4, 8'hB2, 1, 0);
        exp_load(5'd5, 8'hC3, 1, 1);
        send(8'h83);
        chk("hdr_busy", busy, 1);
        send(8'h03); send(8'hA1); send(8'hB2); send(8'hC3);
        wait_cycles(2);
        chk("f1_busy", busy, 0);
        chk("f1_cpu_reset", cpu_reset, 1);
        chk("hold_data", cpu_input, 8'hC3);
        chk("hold_addr", load_address, 5);
        chk("hold_inst", is_instruction, 1);

        exp_load(5'd14, 8'h11, 0, 0);
        exp_load(5'd15, 8'h22, 0, 0);
        exp_load(5'd0, 8'h33, 0, 0);
        exp_load(5'd1, 8'h44, 0, 1);
        send(8'h0E); send(8'h04); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        wait_cycles(2);

        exp_load(5'd31, 8'hAA, 1, 0);
        exp_load(5'd0, 8'hBB, 1, 1);
        send(8'h9F); send(8'h02); send(8'hAA); send(8'hBB);
        wait_cycles(2);

        exp_flag(1, 0);
        send(8'h40);
        chk("run_cpu_reset", cpu_reset, 0);
        send(8'h80);
        chk("halt_cpu_reset", cpu_reset, 1);
        chk("halt_busy", busy, 1);
        exp_flag(1, 0);
        send(8'h00);
        chk("len0_busy", busy, 0);
        wait_cycles(2);

        exp_load(5'd0, 8'h55, 1, 0);
        exp_flag(0, 1);
        send(8'h80); send(8'h02); send(8'h55);
        wait_cycles(3);
        chk("pre_tmo_busy", busy, 1);
        wait_cycles(1);
        chk("tmo_pulse", timeout_err, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_cpu_reset", cpu_reset, 1);
        exp_flag(1, 0);
        send(8'h40);
        chk("tmo_run_cpu_reset", cpu_reset, 0);
        wait_cycles(2);

        exp_load(5'd0, 8'h01, 1, 0);
        send(8'h80); send(8'h05); send(8'h01); send(8'h02);
        reset = 1'b1;
        #1;
        chk("mid_rst_load", load, 0);
        chk("mid_rst_cpu_reset", cpu_reset, 1);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_load(5'd5, 8'h77, 1, 1);
        send(8'h85); send(8'h01); send(8'h77);
        wait_cycles(3);
        chk("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_program_loader.md
Name: cpu_program_loader

Overview:
Host-side byte-stream loader that drives the CPU's program/data load interface (cpu_input, load_address, load, is_instruction) and its reset. It parses framed bytes from a valid/ready byte source, such as a UART receiver or a testbench driver, into one load strobe per payload byte. It holds the CPU in reset while loading and releases it on a RUN command.

Parameters:
IADDR_W, 5, instruction memory address width (load_address width)
DADDR_W, 4, data memory address width (data loads wrap within 2^DADDR_W)
TIMEOUT, 255, idle cycles allowed between bytes inside a frame before abort; 0 disables timeout

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous active-high reset
in_data  in  8  incoming stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts byte; a byte transfers when in_valid && in_ready on a clk edge
cpu_input  out  8  byte to CPU load port
load_address  out  IADDR_W  target address; bits above DADDR_W-1 are 0 for data loads
load  out  1  one-cycle load strobe to CPU
is_instruction  out  1  1 = instruction memory, 0 = data memory; valid with load
cpu_reset  out  1  drives CPU reset; 1 = CPU held
frame_done  out  1  one-cycle pulse at end of a frame or RUN command
timeout_err  out  1  one-cycle pulse when a frame is aborted by timeout
busy  out  1  1 while in LEN or DATA state

Behaviour:
- Reset (async): state=IDLE; cpu_input=0, load_address=0, load=0, is_instruction=0, frame_done=0, timeout_err=0, busy=0; cpu_reset=1; in_ready=0 while reset is high.
- in_ready=1 in every state once reset is low. No backpressure: one byte per cycle is sustained.
- Frame format: HEADER, LEN, then LEN payload bytes.
- HEADER bit7 = is_instruction, bit6 = RUN, bit5 reserved (ignored), bits4:0 = start address.
- States: IDLE, LEN, DATA.
- IDLE, header accepted with bit6=1 (RUN):
  - cpu_reset=0 next cycle.
  - frame_done pulses next cycle.
  - Stay in IDLE; no LEN byte follows.
- IDLE, header accepted with bit6=0:
  - Latch is_instruction and start address. Data frames mask the address to DADDR_W bits.
  - cpu_reset=1 next cycle; this halts a running CPU.
  - Go to LEN.
- LEN, byte accepted:
  - Latch remaining count = byte.
  - If 0: frame_done pulses next cycle, go to IDLE, no loads.
  - Else go to DATA.
- DATA, byte accepted:
  - Next cycle: load=1, cpu_input=byte, load_address=current address, is_instruction=latched flag. Latency is one cycle.
  - Address increments after each load, mod 2^IADDR_W for instructions and mod 2^DADDR_W for data.
  - Remaining count decrements. On the last byte, frame_done pulses in the same cycle as the final load, and state goes to IDLE.
- load is 0 in every cycle without an accepted payload byte. cpu_input, load_address and is_instruction hold their last values.
- Timeout:
  - Idle counter clears on every accepted byte and counts only in LEN/DATA.
  - When it reaches TIMEOUT with TIMEOUT≠0: timeout_err pulses one cycle, go to IDLE, no further loads, cpu_reset stays 1.
  - A byte accepted on the timeout cycle is treated as a new HEADER in IDLE.
- Loads already issued before an abort are not undone.
- Reset mid-frame: immediate return to reset values and any pending load strobe is dropped.
- busy=1 in LEN and DATA, 0 in IDLE.

Test Plan:
- Reset, then instruction frame 0x83, 0x03, 0xA1, 0xB2, 0xC3 at one byte per cycle -> loads at addresses 3, 4, 5 with data A1, B2, C3 and is_instruction=1 on 3 consecutive cycles; frame_done coincides with the 3rd load; cpu_reset remains 1.
- Data frame 0x0E, 0x04, 0x11, 0x22, 0x33, 0x44 -> data loads at addresses 14, 15, 0, 1 (4-bit wrap), is_instruction=0.
- Instruction frame 0x9F, 0x02, 0xAA, 0xBB -> loads at 31 then 0 (5-bit wrap).
- Header 0x40 -> cpu_reset falls one cycle later, frame_done pulses. Then header 0x80 -> cpu_reset rises one cycle later. Then LEN 0x00 -> frame_done pulses, no load.
- TIMEOUT=4, send 0x80, 0x02, 0x55, then stall -> one load of 0x55, timeout_err pulses after 4 idle cycles, busy=0. Next byte 0x40 is parsed as RUN.
- Assert reset after the 2nd payload byte of a 5-byte frame -> load=0 on the next cycle, cpu_reset=1, state IDLE. A fresh frame afterwards loads normally.
